// File: rtl/store_serializer.sv
// Splits byte/half/word stores into ascending single-byte writes, one per enabled cycle.
// Define IO_BUF_STALL_EN to hold writes into the IO region (addr[17:16]==2'b11) while io_buffer_full is set.
module store_serializer #(
    parameter int ADDR_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              rdy_in,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic              is_byte,
    input  logic              is_half,
    input  logic              is_word,
    input  logic              io_buffer_full,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_a,
    output logic [7:0]        mem_dout,
    output logic              done
);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q;
    logic [2:0]        n_q;
    logic [2:0]        idx_q;

    logic [2:0]        n_req;
    logic              accept, pending, fire, stall, io_region, last;
    logic [ADDR_W-1:0] cur_base, wr_addr;
    logic [31:0]       cur_data;
    logic [2:0]        cur_idx, cur_n;
    logic [7:0]        wr_byte;

    // Byte select and "no select" both mean a single byte.
    assign n_req = is_word ? 3'd4 : is_half ? 3'd2 : (is_byte ? 3'd1 : 3'd1);

    assign req_ready = (state_q == IDLE);
    assign accept    = rdy_in && (state_q == IDLE) && req_valid;
    assign pending   = rdy_in && (state_q == WRITE) && (idx_q != n_q);

    // Byte 0 is issued straight from the request inputs on the accepting edge.
    always_comb begin
        cur_base = addr_q;
        cur_data = data_q;
        cur_idx  = idx_q;
        cur_n    = n_q;
        if (state_q == IDLE) begin
            cur_base = req_addr;
            cur_data = req_data;
            cur_idx  = 3'd0;
            cur_n    = n_req;
        end
    end

    assign wr_addr = cur_base + ADDR_W'(cur_idx);
    assign wr_byte = cur_data[cur_idx[1:0]*8 +: 8];
    assign last    = (cur_idx + 3'd1) == cur_n;

    generate
        if (ADDR_W >= 18) begin : g_io_dec
            assign io_region = (wr_addr[17:16] == 2'b11);
        end else begin : g_no_io
            assign io_region = 1'b0;
        end
    endgenerate

`ifdef IO_BUF_STALL_EN
    assign stall = io_buffer_full && io_region;
`else
    assign stall = io_buffer_full & io_region & 1'b0;
`endif

    assign fire = (accept || pending) && !stall;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = WRITE;
            WRITE:   if (rdy_in && idx_q == n_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            addr_q   <= '0;
            data_q   <= '0;
            n_q      <= 3'd0;
            idx_q    <= 3'd0;
            mem_wr   <= 1'b0;
            mem_a    <= '0;
            mem_dout <= 8'd0;
            done     <= 1'b0;
        end else if (rdy_in) begin
            if (accept) begin
                addr_q <= req_addr;
                data_q <= req_data;
                n_q    <= n_req;
            end
            if (fire) begin
                mem_wr   <= 1'b1;
                mem_a    <= wr_addr;
                mem_dout <= wr_byte;
                done     <= last;
                idx_q    <= cur_idx + 3'd1;
            end else begin
                mem_wr <= 1'b0;
                done   <= 1'b0;
                if (state_d == IDLE) idx_q <= 3'd0;
            end
        end else begin
            mem_wr <= 1'b0;
            done   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_store_serializer.sv
// Bench for store_serializer: directed vector table, multi-cycle corner sequences, random scoreboard run.
module tb_store_serializer;

    logic        clk = 1'b0, rst_n = 1'b0, rdy = 1'b1, req_valid = 1'b0;
    logic        is_byte = 1'b0, is_half = 1'b0, is_word = 1'b0, io_full = 1'b0;
    logic [31:0] req_addr = '0, req_data = '0;
    logic        req_ready, mem_wr, done;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;

    store_serializer #(.ADDR_W(32)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .is_byte(is_byte), .is_half(is_half), .is_word(is_word),
        .io_buffer_full(io_full),
        .mem_wr(mem_wr), .mem_a(mem_a), .mem_dout(mem_dout), .done(done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  sel;        // {is_word, is_half, is_byte}
        int          n;
        logic [31:0] exp_a0;
        logic [31:0] exp_bytes;  // byte k expected at exp_a0 + k
    } vec_t;

    vec_t vecs[7];

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
        logic        last;
    } wr_t;

    wr_t exp_q[$];
    bit  draining = 1'b0;
    bit  prev_rdy = 1'b1, prev_full = 1'b0;

    task automatic run_vec(input vec_t v, input int i);
        logic [31:0] ea;
        @(negedge clk);
        chk($sformatf("v%0d_ready_idle", i), {63'd0, req_ready}, 64'd1);
        req_addr = v.addr; req_data = v.data;
        {is_word, is_half, is_byte} = v.sel;
        req_valid = 1'b1;
        for (int k = 0; k < v.n; k++) begin
            @(negedge clk);
            ea = v.exp_a0 + 32'(k);
            chk($sformatf("v%0d_b%0d_wr", i, k), {63'd0, mem_wr}, 64'd1);
            chk($sformatf("v%0d_b%0d_addr", i, k), {32'd0, mem_a}, {32'd0, ea});
            chk($sformatf("v%0d_b%0d_data", i, k), {56'd0, mem_dout}, {56'd0, v.exp_bytes[8*k +: 8]});
            chk($sformatf("v%0d_b%0d_done", i, k), {63'd0, done}, {63'd0, k == v.n - 1});
            chk($sformatf("v%0d_b%0d_busy", i, k), {63'd0, req_ready}, 64'd0);
            // Request inputs must be ignored while writing.
            req_addr = $urandom; req_data = $urandom;
        end
        @(negedge clk);
        chk($sformatf("v%0d_after_wr", i), {62'd0, mem_wr, done}, 64'd0);
        chk($sformatf("v%0d_after_ready", i), {63'd0, req_ready}, 64'd1);
        req_valid = 1'b0;
    endtask

    task automatic monitor();
        wr_t e;
        chk("rand_ready", {63'd0, req_ready}, {63'd0, exp_q.size() == 0 && !draining});
        if (mem_wr) begin
            chk("rand_frozen_wr", {63'd0, !prev_rdy}, 64'd0);
`ifdef IO_BUF_STALL_EN
            chk("rand_io_stall", {63'd0, prev_full && mem_a[17:16] == 2'b11}, 64'd0);
`endif
            if (exp_q.size() == 0) begin
                chk("rand_spurious_wr", {63'd0, mem_wr}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rand_addr", {32'd0, mem_a}, {32'd0, e.a});
                chk("rand_data", {56'd0, mem_dout}, {56'd0, e.d});
                chk("rand_done", {63'd0, done}, {63'd0, e.last});
                if (e.last) draining = 1'b1;
            end
        end else begin
            chk("rand_idle_done", {63'd0, done}, 64'd0);
        end
    endtask

    initial begin
        vecs[0] = '{32'h0000_1000, 32'hDEAD_BEEF, 3'b100, 4, 32'h0000_1000, 32'hDEAD_BEEF};
        vecs[1] = '{32'h0000_2002, 32'h1234_5678, 3'b010, 2, 32'h0000_2002, 32'h0000_5678};
        vecs[2] = '{32'hFFFF_FFFE, 32'hCAFE_F00D, 3'b100, 4, 32'hFFFF_FFFE, 32'hCAFE_F00D};
        vecs[3] = '{32'h0000_0040, 32'h1122_3344, 3'b000, 1, 32'h0000_0040, 32'h0000_0044};
        vecs[4] = '{32'h0000_0050, 32'hAABB_CCDD, 3'b111, 4, 32'h0000_0050, 32'hAABB_CCDD};
        vecs[5] = '{32'h0000_0060, 32'h9988_7766, 3'b011, 2, 32'h0000_0060, 32'h0000_7766};
        vecs[6] = '{32'h0003_FFFF, 32'h0000_00A5, 3'b001, 1, 32'h0003_FFFF, 32'h0000_00A5};

        // Reset state, before and across clock edges.
        #3;
        chk("rst_outputs", {mem_a, mem_dout, 22'd0, mem_wr, done}, 64'd0);
        chk("rst_ready", {63'd0, req_ready}, 64'd1);
        @(negedge clk);
        @(negedge clk);
        chk("rst_outputs_clk", {mem_a, mem_dout, 22'd0, mem_wr, done}, 64'd0);
        chk("rst_ready_clk", {63'd0, req_ready}, 64'd1);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i], i);

        // rdy_in low for two cycles after byte 1 of a word store.
        @(negedge clk);
        req_addr = 32'h0000_5000; req_data = 32'h4433_2211; {is_word, is_half, is_byte} = 3'b100;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("stl_b0", {mem_a, mem_dout, 22'd0, mem_wr, done}, {32'h5000, 8'h11, 24'd2});
        @(negedge clk);
        chk("stl_b1", {mem_a, mem_dout, 22'd0, mem_wr, done}, {32'h5001, 8'h22, 24'd2});
        rdy = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk($sformatf("stl_frozen%0d", c), {62'd0, mem_wr, done}, 64'd0);
            chk($sformatf("stl_frozen_busy%0d", c), {63'd0, req_ready}, 64'd0);
        end
        rdy = 1'b1;
        @(negedge clk);
        chk("stl_b2", {mem_a, mem_dout, 22'd0, mem_wr, done}, {32'h5002, 8'h33, 24'd2});
        @(negedge clk);
        chk("stl_b3", {mem_a, mem_dout, 22'd0, mem_wr, done}, {32'h5003, 8'h44, 24'd3});
        @(negedge clk);
        chk("stl_end", {61'd0, req_ready, mem_wr, done}, 64'd4);

        // Reset in the middle of a word store.
        req_addr = 32'h0000_6000; req_data = 32'h8877_6655; {is_word, is_half, is_byte} = 3'b100;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("mid_b1", {mem_a, mem_dout, 22'd0, mem_wr, done}, {32'h6001, 8'h66, 24'd2});
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_out", {mem_a, mem_dout, 22'd0, mem_wr, done}, 64'd0);
        chk("mid_rst_ready", {63'd0, req_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("mid_quiet%0d", c), {61'd0, req_ready, mem_wr, done}, 64'd4);
        end

        // Byte store into the IO region while the IO buffer is full for three edges.
        req_addr = 32'h0003_0000; req_data = 32'h0000_00A5; {is_word, is_half, is_byte} = 3'b001;
        req_valid = 1'b1; io_full = 1'b1;
`ifdef IO_BUF_STALL_EN
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            chk($sformatf("io_hold%0d", c), {61'd0, req_ready, mem_wr, done}, 64'd0);
            if (c == 3) io_full = 1'b0;
        end
`endif
        @(negedge clk);
        req_valid = 1'b0; io_full = 1'b0;
        chk("io_write", {mem_a, mem_dout, 22'd0, mem_wr, done}, {32'h3_0000, 8'hA5, 24'd3});
        @(negedge clk);
        chk("io_end", {61'd0, req_ready, mem_wr, done}, 64'd4);

        // Random traffic against a transaction-level scoreboard.
        prev_rdy = 1'b1; prev_full = 1'b0; draining = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            bit idle_now;
            int n;
            monitor();
            idle_now = exp_q.size() == 0 && !draining;
            rdy       = ($urandom_range(0, 9) < 8);
            req_valid = ($urandom_range(0, 9) < 6);
            io_full   = ($urandom_range(0, 9) < 3);
            req_data  = $urandom;
            {is_word, is_half, is_byte} = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       req_addr = {$urandom_range(0, 65535) > 0 ? 14'($urandom) : 14'h3FFF, 2'b11, 16'($urandom)};
                1:       req_addr = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
                default: req_addr = $urandom;
            endcase
            if (rdy) begin
                if (draining) begin
                    draining = 1'b0;
                end else if (idle_now && req_valid) begin
                    n = is_word ? 4 : is_half ? 2 : 1;
                    for (int k = 0; k < n; k++)
                        exp_q.push_back('{req_addr + 32'(k), 8'((req_data >> (8 * k)) & 32'hFF), k == n - 1});
                end
            end
            prev_rdy = rdy; prev_full = io_full;
            @(negedge clk);
        end

        // Drain with a bounded wait.
        req_valid = 1'b0; rdy = 1'b1; io_full = 1'b0;
        for (int c = 0; c < 20; c++) begin
            monitor();
            if (rdy && draining) draining = 1'b0;
            prev_rdy = 1'b1; prev_full = 1'b0;
            @(negedge clk);
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        chk("drain_ready", {63'd0, req_ready}, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
